// File: rtl/ram_8x4_pkg.sv
// ram_8x4_pkg: shared widths, word/address types and parity helper for the 8x4 RAM.
package ram_8x4_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    function automatic logic even_parity(word_t w);
        return ^w;
    endfunction
endpackage

// File: rtl/ram_8x4_if.sv
// ram_8x4_if: access bus of the 8x4 RAM; parity_err exists only with RAM_8X4_PARITY_EN.
interface ram_8x4_if;
    ram_8x4_pkg::addr_t address;
    ram_8x4_pkg::word_t data_in;
    logic               write_enable;
    logic               read_enable;
    ram_8x4_pkg::word_t data_out;
    logic               rd_valid;
`ifdef RAM_8X4_PARITY_EN
    logic               parity_err;
`endif
    modport master (
        output address, data_in, write_enable, read_enable,
`ifdef RAM_8X4_PARITY_EN
        input  parity_err,
`endif
        input  data_out, rd_valid
    );
    modport slave (
        input  address, data_in, write_enable, read_enable,
`ifdef RAM_8X4_PARITY_EN
        output parity_err,
`endif
        output data_out, rd_valid
    );
endinterface

// File: rtl/ram_8x4_parity_chk.sv
// ram_8x4_parity_chk: even-parity generation for writes and mismatch detection for reads.
module ram_8x4_parity_chk
    import ram_8x4_pkg::*;
(
    input  word_t wdata_i,
    input  word_t rdata_i,
    input  logic  rpar_i,
    output logic  wpar_o,
    output logic  err_o
);
    assign wpar_o = even_parity(wdata_i);
    assign err_o  = even_parity(rdata_i) != rpar_i;
endmodule

// File: rtl/ram_8x4_core.sv
// ram_8x4_core: 8x4 single-port synchronous RAM, write-through on simultaneous strobes.
// Optional per-word even parity with registered parity_err under RAM_8X4_PARITY_EN.
module ram_8x4_core
    import ram_8x4_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    ram_8x4_if.slave bus
);
    word_t mem_q [DEPTH];
    word_t data_q, data_d;
    logic  vld_q, vld_d;
    always_comb begin
        data_d = bus.read_enable ? (bus.write_enable ? bus.data_in : mem_q[bus.address]) : data_q;
        vld_d  = bus.read_enable;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (bus.write_enable) mem_q[bus.address] <= bus.data_in;
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end
    assign bus.data_out = data_q;
    assign bus.rd_valid = vld_q;
`ifdef RAM_8X4_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             wpar, chk_err, perr_q, perr_d;
    ram_8x4_parity_chk u_par (
        .wdata_i (bus.data_in),
        .rdata_i (mem_q[bus.address]),
        .rpar_i  (par_q[bus.address]),
        .wpar_o  (wpar),
        .err_o   (chk_err)
    );
    // Write-through reads return data_in directly, so stored parity is irrelevant there.
    always_comb perr_d = bus.read_enable && !bus.write_enable && chk_err;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            if (bus.write_enable) par_q[bus.address] <= wpar;
            perr_q <= perr_d;
        end
    end
    assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_ram_8x4_core.sv
// tb_ram_8x4_core: table-driven scoreboard bench for ram_8x4_core.
module tb_ram_8x4_core;
    typedef struct {
        logic       we;
        logic       re;
        logic [2:0] addr;
        logic [3:0] din;
        logic [3:0] dout;
        logic       vld;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    vec_t sb[$];

    ram_8x4_if bus();
    ram_8x4_core dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [2:0] a, input logic [3:0] d);
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.address      = a;
        bus.data_in      = d;
    endtask

    task automatic step(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v.we, v.re, v.addr, v.din);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d data_out", idx), bus.data_out, e.dout);
            chk($sformatf("vec%0d rd_valid", idx), {3'b0, bus.rd_valid}, {3'b0, e.vld});
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) vecs.push_back('{1'b0, 1'b1, 3'(a), 4'h0, 4'b0000, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 4'b1111, 4'b0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 4'b0110, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 4'b0000, 4'b1111, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b0000, 4'b0110, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 4'b0000, 4'b0110, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b1001, 4'b0000, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 4'b1010, 4'b1010, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 4'b0000, 4'b1010, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 4'b0000, 4'b1111, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 4'b0000, 4'b1010, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 4'b1100, 4'b1010, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd2, 4'b0000, 4'b1100, 1'b1});

        drive(1'b0, 1'b0, 3'd0, 4'h0);
        reset = 1'b1;
        #10;
        reset = 1'b0;
        chk("reset data_out", bus.data_out, 4'b0000);
        chk("reset rd_valid", {3'b0, bus.rd_valid}, 4'b0000);

        foreach (vecs[i]) step(i, vecs[i]);

        // Reset lands between edges while a write to addr 6 is pending.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd6, 4'b1001);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst data_out", bus.data_out, 4'b0000);
        chk("midrst rd_valid", {3'b0, bus.rd_valid}, 4'b0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 4'h0);
        reset = 1'b0;
        step(100, '{1'b0, 1'b1, 3'd2, 4'h0, 4'b0000, 1'b1});
        step(101, '{1'b0, 1'b1, 3'd6, 4'h0, 4'b0000, 1'b1});
        step(102, '{1'b0, 1'b1, 3'd3, 4'h0, 4'b0000, 1'b1});

`ifdef RAM_8X4_PARITY_EN
        step(200, '{1'b1, 1'b0, 3'd1, 4'b0111, 4'b0000, 1'b0});
        step(201, '{1'b0, 1'b1, 3'd1, 4'b0000, 4'b0111, 1'b1});
        chk("par clean", {3'b0, bus.parity_err}, 4'b0000);
        @(negedge clk);
        dut.par_q[1] = ~dut.par_q[1];
        step(202, '{1'b0, 1'b1, 3'd1, 4'b0000, 4'b0111, 1'b1});
        chk("par flipped", {3'b0, bus.parity_err}, 4'b0001);
        step(203, '{1'b0, 1'b0, 3'd1, 4'b0000, 4'b0111, 1'b0});
        chk("par one-shot", {3'b0, bus.parity_err}, 4'b0000);
        step(204, '{1'b1, 1'b1, 3'd1, 4'b0011, 4'b0011, 1'b1});
        chk("par wthru", {3'b0, bus.parity_err}, 4'b0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
